// File: rtl/gl_cmd_issue_if.sv
// rtl/gl_cmd_issue_if.sv - command-memory, run-control and decoder signals of the GL command issuer
interface gl_cmd_issue_if #(
  parameter int CMD_AW = 16
);
  logic              start;
  logic [CMD_AW-1:0] cmd_base;
  logic [CMD_AW-1:0] cmd_count;
  logic              cmd_rd_en;
  logic [CMD_AW-1:0] cmd_addr;
  logic [31:0]       cmd_data;
  logic              stall;
  logic [7:0]        opcode;
  logic              op_type;
  logic [22:0]       imm;
  logic [31:0]       operand_addr;
  logic              busy;
  logic              done;
  logic [CMD_AW-1:0] cmd_index;

  modport master (
    input  start, cmd_base, cmd_count, cmd_data, stall,
    output cmd_rd_en, cmd_addr, opcode, op_type, imm, operand_addr, busy, done, cmd_index
  );

  modport slave (
    output start, cmd_base, cmd_count, cmd_data, stall,
    input  cmd_rd_en, cmd_addr, opcode, op_type, imm, operand_addr, busy, done, cmd_index
  );
endinterface

// File: rtl/gl_cmd_issue.sv
// rtl/gl_cmd_issue.sv - fetches GL command words and presents them to gl_decode, honouring its stall
module gl_cmd_issue #(
  parameter int          CMD_AW       = 16,
  parameter logic [31:0] OPERAND_BASE = 32'h0000_0000,
  parameter int          MIN_DWELL    = 2,
  parameter int          TAIL_CYCLES  = 2,
  parameter logic [7:0]  NOP_OP       = 8'hFF
) (
  input logic            clk,
  input logic            reset,
  gl_cmd_issue_if.master bus
);
  localparam int DW = (MIN_DWELL < 2) ? 1 : $clog2(MIN_DWELL + 1);
  localparam int TW = (TAIL_CYCLES < 2) ? 1 : $clog2(TAIL_CYCLES);
  localparam logic [DW-1:0] DWELL_MIN = DW'(MIN_DWELL);
  localparam logic [TW-1:0] TAIL_LAST = TW'((TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_TAIL, S_END} state_t;

  state_t            state, next_state;
  logic [CMD_AW-1:0] base_q, count_q, idx_q;
  logic [CMD_AW:0]   next_idx;
  logic              more;
  logic [DW-1:0]     dwell;
  logic              first_hold;
  logic [TW-1:0]     tail_cnt;
  logic              pf_pending, pf_valid;
  logic [31:0]       pf_buf;
  logic              rd_en;
  logic [CMD_AW-1:0] rd_addr;
  logic              load_first, load_pf, finish, tail_end;
  logic [31:0]       load_word;
  logic [7:0]        opcode_q;
  logic              type_q;
  logic [22:0]       imm_q;
  logic [31:0]       oaddr_q;
  logic              busy_q, done_q;

  assign next_idx  = {1'b0, idx_q} + (CMD_AW + 1)'(1);
  assign more      = next_idx < {1'b0, count_q};
  assign load_word = load_first ? bus.cmd_data : pf_buf;

  assign bus.cmd_rd_en    = rd_en;
  assign bus.cmd_addr     = rd_addr;
  assign bus.opcode       = opcode_q;
  assign bus.op_type      = type_q;
  assign bus.imm          = imm_q;
  assign bus.operand_addr = oaddr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cmd_index    = idx_q;

  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    load_first = 1'b0;
    load_pf    = 1'b0;
    finish     = 1'b0;
    tail_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) next_state = (bus.cmd_count == '0) ? S_END : S_FETCH;
      end
      S_FETCH: begin
        rd_en      = 1'b1;
        rd_addr    = base_q;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        load_first = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        // Prefetch the next word once per command so it is ready before the tail drains.
        if (first_hold && more) begin
          rd_en   = 1'b1;
          rd_addr = base_q + next_idx[CMD_AW-1:0];
        end
        if (dwell >= DWELL_MIN && !bus.stall) begin
          if (TAIL_CYCLES == 0) tail_end = 1'b1;
          else next_state = S_TAIL;
        end
      end
      S_TAIL: tail_end = (tail_cnt == TAIL_LAST);
      S_END: begin
        finish     = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    // A drained tail either retires the run or swaps in the prefetched word without a NOP gap.
    if (tail_end) begin
      if (!more) begin
        finish     = 1'b1;
        next_state = S_IDLE;
      end else if (pf_valid) begin
        load_pf    = 1'b1;
        next_state = S_HOLD;
      end else begin
        next_state = S_TAIL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      dwell      <= '0;
      first_hold <= 1'b0;
      tail_cnt   <= '0;
      pf_pending <= 1'b0;
      pf_valid   <= 1'b0;
      pf_buf     <= '0;
      opcode_q   <= NOP_OP;
      type_q     <= 1'b0;
      imm_q      <= '0;
      oaddr_q    <= OPERAND_BASE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= next_state;
      done_q     <= finish;
      first_hold <= load_first | load_pf;
      pf_pending <= rd_en && (state == S_HOLD);
      if (state == S_IDLE && bus.start) begin
        base_q  <= bus.cmd_base;
        count_q <= bus.cmd_count;
        busy_q  <= 1'b1;
      end
      if (pf_pending) begin
        pf_buf   <= bus.cmd_data;
        pf_valid <= 1'b1;
      end
      if (load_first || load_pf) begin
        opcode_q <= load_word[31:24];
        type_q   <= load_word[23];
        imm_q    <= load_word[22:0];
        if (load_word[23]) oaddr_q <= OPERAND_BASE + {5'b0, load_word[22:0], 4'b0};
        dwell    <= DW'(1);
        idx_q    <= load_first ? '0 : next_idx[CMD_AW-1:0];
        pf_valid <= 1'b0;
      end else if (state == S_HOLD && dwell < DWELL_MIN) begin
        dwell <= dwell + DW'(1);
      end
      if (state == S_HOLD && next_state == S_TAIL) tail_cnt <= '0;
      else if (state == S_TAIL && tail_cnt != TAIL_LAST) tail_cnt <= tail_cnt + TW'(1);
      if (finish) begin
        busy_q   <= 1'b0;
        opcode_q <= NOP_OP;
        type_q   <= 1'b0;
        imm_q    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gl_cmd_issue.sv
// tb/tb_gl_cmd_issue.sv - randomized self-checking bench for gl_cmd_issue
module tb_gl_cmd_issue;
  localparam int          CMD_AW       = 16;
  localparam logic [31:0] OPERAND_BASE = 32'h0000_0000;
  localparam int          MIN_DWELL    = 2;
  localparam int          TAIL_CYCLES  = 2;
  localparam logic [7:0]  NOP_OP       = 8'hFF;
  localparam int          PLAN         = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  gl_cmd_issue_if #(.CMD_AW(CMD_AW)) bus ();

  gl_cmd_issue #(
    .CMD_AW(CMD_AW), .OPERAND_BASE(OPERAND_BASE), .MIN_DWELL(MIN_DWELL),
    .TAIL_CYCLES(TAIL_CYCLES), .NOP_OP(NOP_OP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0]       mem [0:65535];
  logic [CMD_AW-1:0] rd_log [$];
  bit                stall_plan [0:PLAN-1];
  logic [31:0]       model_oaddr;
  int                done_at;

  // Command memory with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.cmd_rd_en) begin
      bus.cmd_data <= mem[bus.cmd_addr];
      rd_log.push_back(bus.cmd_addr);
    end
  end

  function automatic bit plan_stall(input int c);
    return (c >= 0 && c < PLAN) ? stall_plan[c] : 1'b0;
  endfunction

  task automatic set_plan(input int pct);
    for (int i = 0; i < PLAN; i++) stall_plan[i] = ($urandom_range(0, 99) < pct) && (i < PLAN - 100);
  endtask

  task automatic fill_words(input logic [CMD_AW-1:0] base, input int count);
    for (int i = 0; i < count; i++) mem[base + CMD_AW'(i)] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_oaddr = OPERAND_BASE;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.opcode !== NOP_OP || bus.op_type !== 1'b0 || bus.imm !== 23'd0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.operand_addr !== OPERAND_BASE || bus.cmd_rd_en !== 1'b0 || bus.cmd_index !== '0) begin
        errors++;
        $display("FAIL reset_idle c=%0d opcode=%h busy=%b done=%b oaddr=%h rd_en=%b idx=%0d, expected opcode=%h all else 0",
                 c, bus.opcode, bus.busy, bus.done, bus.operand_addr, bus.cmd_rd_en, bus.cmd_index, NOP_OP);
      end
      bus.stall = (c % 2 == 0);
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_stream(input string name, input logic [CMD_AW-1:0] base, input int count, input int restart_at);
    logic [31:0] exp_w [int];
    int          exp_i [int];
    logic [31:0] exp_oa [int];
    logic [31:0] w, oa;
    int          t, k;
    oa = model_oaddr;
    t  = 2;
    for (int i = 0; i < count; i++) begin
      w = mem[base + CMD_AW'(i)];
      if (w[23]) oa = OPERAND_BASE + 32'(w[22:0]) * 32'd16;
      k = 1;
      while (!(k >= MIN_DWELL && !plan_stall(t + k - 1))) k++;
      for (int j = 0; j < k + TAIL_CYCLES; j++) begin
        exp_w[t + j] = w; exp_i[t + j] = i; exp_oa[t + j] = oa;
      end
      t += k + TAIL_CYCLES;
    end
    rd_log.delete();
    done_at = -1;
    @(negedge clk);
    bus.cmd_base = base; bus.cmd_count = CMD_AW'(count); bus.start = 1'b1; bus.stall = 1'b0;
    for (int c = 0; c <= t + 1; c++) begin
      @(negedge clk);
      checks++;
      if (c < 2) begin
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.opcode !== NOP_OP) begin
          errors++;
          $display("FAIL %s startup c=%0d busy=%b done=%b opcode=%h, expected busy=1 done=0 opcode=%h",
                   name, c, bus.busy, bus.done, bus.opcode, NOP_OP);
        end
      end else if (c < t) begin
        if ({bus.opcode, bus.op_type, bus.imm} !== exp_w[c] || bus.operand_addr !== exp_oa[c] ||
            bus.cmd_index !== CMD_AW'(exp_i[c]) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL %s issue c=%0d word=%h oaddr=%h idx=%0d busy=%b done=%b, expected word=%h oaddr=%h idx=%0d busy=1 done=0",
                   name, c, {bus.opcode, bus.op_type, bus.imm}, bus.operand_addr, bus.cmd_index, bus.busy, bus.done,
                   exp_w[c], exp_oa[c], exp_i[c]);
        end
      end else if (c == t) begin
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.opcode !== NOP_OP || bus.op_type !== 1'b0 ||
            bus.imm !== 23'd0 || bus.operand_addr !== oa) begin
          errors++;
          $display("FAIL %s done_cycle c=%0d done=%b busy=%b opcode=%h oaddr=%h, expected done=1 busy=0 opcode=%h oaddr=%h",
                   name, c, bus.done, bus.busy, bus.opcode, bus.operand_addr, NOP_OP, oa);
        end
      end else begin
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.opcode !== NOP_OP) begin
          errors++;
          $display("FAIL %s after_done c=%0d done=%b busy=%b opcode=%h, expected 0 0 %h",
                   name, c, bus.done, bus.busy, bus.opcode, NOP_OP);
        end
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
      bus.start = (c == restart_at);
      if (bus.start) begin
        bus.cmd_base  = base + CMD_AW'(7);
        bus.cmd_count = CMD_AW'(count + 2);
      end
      bus.stall = plan_stall(c);
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    model_oaddr = oa;
    checks++;
    if (rd_log.size() != count) begin
      errors++;
      $display("FAIL %s read_count got=%0d expected=%0d", name, rd_log.size(), count);
    end else begin
      for (int i = 0; i < count; i++) begin
        checks++;
        if (rd_log[i] !== base + CMD_AW'(i)) begin
          errors++;
          $display("FAIL %s read_addr[%0d] got=%h expected=%h", name, i, rd_log[i], base + CMD_AW'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    mem[16'h10] = 32'h1200_0000; mem[16'h11] = 32'h1400_0000; mem[16'h12] = 32'h1500_0000;
    set_plan(0);
    test_stream("back_to_back", 16'h0010, 3, -1);
    checks++;
    if (done_at != 14) begin
      errors++;
      $display("FAIL back_to_back done_time got=%0d expected=14", done_at);
    end
  endtask

  task automatic test_stall();
    mem[16'h30] = 32'h1380_0005;
    set_plan(0);
    for (int c = 3; c <= 5; c++) stall_plan[c] = 1'b1;
    test_stream("stall", 16'h0030, 1, -1);
    checks++;
    if (done_at != 9 || bus.operand_addr !== 32'h0000_0050) begin
      errors++;
      $display("FAIL stall_hold done_time=%0d oaddr=%h, expected done_time=9 oaddr=00000050", done_at, bus.operand_addr);
    end
  endtask

  task automatic test_count_zero();
    rd_log.delete();
    @(negedge clk);
    bus.cmd_base = 16'h0040; bus.cmd_count = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL count_zero c0 busy=%b done=%b, expected busy=1 done=0", bus.busy, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL count_zero c1 busy=%b done=%b, expected busy=0 done=1", bus.busy, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.opcode !== NOP_OP || rd_log.size() != 0) begin
      errors++;
      $display("FAIL count_zero c2 busy=%b done=%b opcode=%h reads=%0d, expected 0 0 %h 0",
               bus.busy, bus.done, bus.opcode, rd_log.size(), NOP_OP);
    end
  endtask

  task automatic test_double_start();
    fill_words(16'h0050, 2);
    set_plan(0);
    test_stream("double_start", 16'h0050, 2, 3);
  endtask

  task automatic test_reset_mid_run();
    logic [CMD_AW-1:0] base;
    base = 16'h0200;
    fill_words(base, 3);
    set_plan(0);
    @(negedge clk);
    bus.cmd_base = base; bus.cmd_count = CMD_AW'(3); bus.start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.opcode !== mem[base][31:24] || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre opcode=%h busy=%b, expected opcode=%h busy=1", bus.opcode, bus.busy, mem[base][31:24]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_oaddr = OPERAND_BASE;
    checks++;
    if (bus.opcode !== NOP_OP || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.operand_addr !== OPERAND_BASE) begin
      errors++;
      $display("FAIL reset_mid post opcode=%h busy=%b done=%b oaddr=%h, expected %h 0 0 %h",
               bus.opcode, bus.busy, bus.done, bus.operand_addr, NOP_OP, OPERAND_BASE);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid quiet c=%0d done=%b busy=%b rd_en=%b, expected all 0", c, bus.done, bus.busy, bus.cmd_rd_en);
      end
    end
    test_stream("reset_replay", base, 3, -1);
  endtask

  task automatic test_random();
    logic [CMD_AW-1:0] base;
    int                count;
    for (int r = 0; r < 6; r++) begin
      base  = (r == 0) ? 16'hFFFE : CMD_AW'($urandom);
      count = $urandom_range(1, 5);
      fill_words(base, count);
      set_plan(35);
      test_stream("random", base, count, -1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_count_zero();
    test_double_start();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gl_cmd_issue.md
Name: gl_cmd_issue

Overview:
- Command issuer that feeds gl_decode: fetches 32-bit GL command words from command memory, splits them into opcode/type/imm, and presents each one to the decoder.
- Honours the decoder's stall so that multi-cycle ops (vertex, matrix multiply, load matrix) complete before the next command is presented.
- Generates the operand BRAM byte address that drives the decoder's bram_addr_in.
- Sits between the host-loaded command buffer and gl_decode.

Parameters:
- CMD_AW, 16, command memory word-address width.
- OPERAND_BASE, 32'h00000000, byte base address of the operand BRAM region.
- MIN_DWELL, 2, minimum cycles each opcode is held before stall is honoured (stall rises one cycle after the opcode appears).
- TAIL_CYCLES, 2, cycles the opcode is still held after stall is seen low, so the decoder's countdown can drain.
- NOP_OP, 8'hFF, opcode driven when idle; gl_decode ignores it.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- cmd_base  in  CMD_AW  word address of the first command.
- cmd_count  in  CMD_AW  number of commands to issue.
- cmd_rd_en  out  1  command memory read strobe; read latency is 1 cycle.
- cmd_addr  out  CMD_AW  command memory word address.
- cmd_data  in  32  command word: [31:24] opcode, [23] type, [22:0] imm.
- stall  in  1  stall from gl_decode.
- opcode  out  8  to decoder.
- type  out  1  to decoder.
- imm  out  23  to decoder.
- operand_addr  out  32  to decoder bram_addr_in.
- busy  out  1  high from the start edge until the done cycle.
- done  out  1  one-cycle pulse when a run finishes.
- cmd_index  out  CMD_AW  index of the command currently presented.

Behaviour:
- Reset values:
  - opcode=NOP_OP; type=0; imm=0.
  - operand_addr=OPERAND_BASE.
  - cmd_rd_en=0; cmd_addr=0; busy=0; done=0; cmd_index=0.
  - All counters 0; prefetch buffer invalid; state IDLE.
- Reset mid-run aborts immediately. No done pulse is generated.
- States: IDLE, FETCH, WAIT, HOLD, TAIL, END.
- IDLE:
  - On start with cmd_count!=0: latch base/count, busy<=1, go to FETCH.
  - On start with cmd_count==0: go to END; done pulses on the next edge.
- FETCH: cmd_rd_en=1, cmd_addr=cmd_base → WAIT.
- WAIT: cmd_data is valid this cycle. On the edge, load the output registers, set cmd_index=0, go to HOLD. The first opcode is visible 2 cycles after the start edge.
- Output load:
  - opcode/type/imm come from the word fields.
  - If type=1: operand_addr = OPERAND_BASE + (imm<<4), mod 2^32 (one 16-byte BRAM row per imm unit).
  - If type=0: operand_addr keeps its previous value.
- HOLD:
  - dwell counter starts at 1 and increments each cycle, saturating at MIN_DWELL.
  - In the first HOLD cycle, if more commands remain: cmd_rd_en=1 for word cmd_index+1. Capture into the prefetch buffer on the next edge, set valid.
  - When dwell>=MIN_DWELL and stall==0: go to TAIL, or act as TAIL-complete if TAIL_CYCLES=0.
  - stall high holds HOLD indefinitely. The outputs stay stable throughout.
- TAIL:
  - Opcode is held for TAIL_CYCLES cycles; stall is ignored here.
  - At the end of TAIL, if commands remain: load the prefetch buffer onto the outputs, cmd_index++, clear valid, go to HOLD. The transition is back-to-back with no NOP gap.
  - At the end of TAIL, if no commands remain: go to END.
- END: opcode<=NOP_OP, type<=0, imm<=0, done<=1 for one cycle, busy<=0 → IDLE. operand_addr keeps its last value.
- Cycles per command (for the first command, measured from when its opcode appears): max(MIN_DWELL, first cycle stall is sampled low at dwell>=MIN_DWELL) + TAIL_CYCLES.
- Prefetch always completes by cycle 2 of HOLD, so with MIN_DWELL>=2 there are no bubbles. If MIN_DWELL=1 and the prefetch is not yet valid, stay in TAIL until it is.
- cmd_addr increments modulo 2^CMD_AW; wrap is permitted.
- start pulses while busy are ignored, including in the END cycle.
- stall pulses while in IDLE are ignored.

Test Plan:
- Reset, then idle → opcode=8'hFF, busy=0, done=0, operand_addr=OPERAND_BASE; no cmd_rd_en.
- start, base=0x10, count=3; words 0x12000000, 0x14000000, 0x15000000; stall tied 0 → opcodes 0x12, 0x14, 0x15 each visible exactly 4 cycles, back-to-back; first opcode 2 cycles after start; done one cycle after the last; 0xFF after done.
- One command 0x13800005 (load matrix, type=1, imm=5); stall high on dwell cycles 2–4 → operand_addr=0x50; opcode held while stall high; held 2 more cycles after stall falls; then done.
- cmd_count=0 → done pulse at start+1, busy high for exactly one cycle, no cmd_rd_en.
- Second start pulse mid-run, count=2 → ignored; exactly 2 commands issued, one done pulse.
- Reset asserted during HOLD of command 1 of 3 → next cycle opcode=0xFF, busy=0, no done; a new start replays from cmd_base.
